// File: rtl/bot_seq_pkg.sv
// Shared types and constants for the rojobot motion sequencer.
// Optional collision stop is enabled by defining BOT_SEQ_COLLISION_STOP_EN.
package bot_seq_pkg;

  localparam int unsigned CMD_TICK_W = 16;

  // Sensors_reg bit that reports a bumper hit.
  localparam int unsigned BOT_SNS_BUMP_BIT = 0;

  localparam logic [7:0] MOT_STOP  = 8'h00;
  localparam logic [7:0] MOT_FWD   = 8'h33;
  localparam logic [7:0] MOT_REV   = 8'hBB;
  localparam logic [7:0] MOT_LEFT  = 8'h3B;
  localparam logic [7:0] MOT_RIGHT = 8'hB3;

  typedef struct packed {
    logic [7:0]            motctl;
    logic [CMD_TICK_W-1:0] ticks;
  } bot_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/bot_cmd_fifo.sv
// Synchronous command FIFO with a registered occupancy count and a flush.
// Pushes into a full FIFO and pops from an empty one are ignored.
module bot_cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DepthC = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == DepthC);
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in) begin
    if (reset || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok && !reset && !flush) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/bot_motion_sequencer.sv
// Timed MotCtl sequencer for rojobot31 plus the bot-update interrupt flag.
// Define BOT_SEQ_COLLISION_STOP_EN to abort the queue on a bumper hit.
module bot_motion_sequencer
  import bot_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TICK_W     = 16,
  parameter logic [7:0]  STOP_CODE  = 8'h00
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [7:0]                  cmd_motctl,
  input  logic [TICK_W-1:0]           cmd_ticks,
  input  logic                        flush,
  input  logic                        upd_sysregs,
  input  logic [7:0]                  sensors_reg,
  input  logic                        int_ack,
  output logic [7:0]                  motctl_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        bot_updt_irq,
  output logic                        abort_flag
);

  localparam logic [1:0] StIdle = IDLE;
  localparam logic [1:0] StLoad = LOAD;
  localparam logic [1:0] StRun  = RUN;

  logic [1:0]        state_q, state_d;
  logic [TICK_W-1:0] remain_q, remain_d;
  logic [7:0]        motctl_q, motctl_d;
  logic              upd_q, upd_edge, irq_q;
  logic              collide, hold, abort;
  logic              fifo_full, fifo_empty;
  logic [7+TICK_W:0] head;
  logic [7:0]        head_motctl;
  logic [TICK_W-1:0] head_ticks;

  assign upd_edge = upd_sysregs & ~upd_q;

`ifdef BOT_SEQ_COLLISION_STOP_EN
  logic bump, abort_q;
  assign bump    = sensors_reg[BOT_SNS_BUMP_BIT];
  assign collide = bump && (state_q == StLoad || state_q == StRun);
  // A bump seen while idle only defers the next load.
  assign hold    = bump;

  always_ff @(posedge clk_in) begin
    if (reset)        abort_q <= 1'b0;
    else if (collide) abort_q <= 1'b1;
    else if (flush)   abort_q <= 1'b0;
  end
  assign abort_flag = abort_q;
`else
  logic unused_sensors;
  assign unused_sensors = ^sensors_reg;
  assign collide        = 1'b0;
  assign hold           = 1'b0;
  assign abort_flag     = 1'b0;
`endif

  assign abort = flush | collide;

  bot_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8 + TICK_W)
  ) u_fifo (
    .clk_in (clk_in),
    .reset  (reset),
    .flush  (abort),
    .push   (cmd_valid),
    .pop    (state_q == StLoad),
    .wdata  ({cmd_motctl, cmd_ticks}),
    .rdata  (head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign head_motctl = head[7+TICK_W:TICK_W];
  assign head_ticks  = head[TICK_W-1:0];
  assign cmd_ready   = ~fifo_full;

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    motctl_d = motctl_q;
    if (abort) begin
      state_d  = StIdle;
      remain_d = '0;
      motctl_d = STOP_CODE;
    end else begin
      unique case (state_q)
        StIdle: begin
          motctl_d = STOP_CODE;
          if (!fifo_empty && !hold) state_d = StLoad;
        end
        StLoad: begin
          motctl_d = head_motctl;
          remain_d = (head_ticks == '0) ? TICK_W'(1) : head_ticks;
          state_d  = StRun;
        end
        StRun: begin
          if (upd_edge) begin
            if (remain_q == TICK_W'(1)) begin
              // Keep driving the old code through LOAD so there is no STOP glitch.
              if (fifo_empty) begin
                state_d  = StIdle;
                motctl_d = STOP_CODE;
              end else begin
                state_d = StLoad;
              end
            end else begin
              remain_d = remain_q - TICK_W'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= StIdle;
      remain_q <= '0;
      motctl_q <= STOP_CODE;
      upd_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      motctl_q <= motctl_d;
      upd_q    <= upd_sysregs;
      if (upd_edge)     irq_q <= 1'b1;
      else if (int_ack) irq_q <= 1'b0;
    end
  end

  assign motctl_out   = motctl_q;
  assign busy         = (state_q == StRun);
  assign bot_updt_irq = irq_q;

endmodule
